message_encryptor: RTL and testbench

Downstream consumer of the public-key generation stage. Once the public key is ready, the block latches Public_key and encrypts a stream of 8-bit plaintext bytes as C = (M + Pk) mod p, with p = 227. Bytes arrive on a valid/ready input handshake and leave on a valid/ready output handshake. The block is active only while the system mode selects encryption.

---
 rtl/crypto_pkg.sv | 22 ++
 rtl/mod_p_reduce.sv | 26 ++
 rtl/message_encryptor.sv | 213 +++++++++++++++++++++
 tb/tb_message_encryptor.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/crypto_pkg.sv
// Shared constants and types for the key-generation / encryption datapath.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package crypto_pkg;

  // Prime modulus shared by key generation and encryption; must stay below 256
  localparam logic [7:0] P_PAR = 8'd227;

  // System mode codes
  localparam logic [1:0] MODE_KEYGEN = 2'b01;
  localparam logic [1:0] MODE_ENC    = 2'b10;

  // Encryptor control states
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
    S_ADD  = 3'd2,
    S_RED  = 3'd3,
    S_OUT  = 3'd4
  } enc_state_t;

endpackage : crypto_pkg

// File: rtl/mod_p_reduce.sv
// Reduces a 9-bit sum of two residues mod P with one conditional subtraction.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of i_sum.
//
// Ports:
//   i_sum  in  9  sum of two operands, each already < P
//   o_res  out 8  i_sum mod P
//
// Inputs are bounded by 2*P-2, so a single subtraction always lands in [0, P).
module mod_p_reduce
  import crypto_pkg::*;
#(
  parameter logic [7:0] P = crypto_pkg::P_PAR
) (
  input  logic [8:0] i_sum,
  output logic [7:0] o_res
);

  logic [8:0] w_diff;
  logic       w_ge_p;

  assign w_diff = i_sum - {1'b0, P};
  assign w_ge_p = (i_sum >= {1'b0, P});
  assign o_res  = w_ge_p ? w_diff[7:0] : i_sum[7:0];

endmodule : mod_p_reduce

// File: rtl/message_encryptor.sv
// Encrypts plaintext bytes as C = (M + Pk) mod P after latching the public key.
// Latency: ctxt_valid rises two edges after the plaintext handshake; 1 byte / 4 cycles peak.
// Backpressure: holds ctxt until ctxt_ready; ptxt_ready is low while a byte is in flight.
//
// Ports:
//   clk, rst_n            clock (rising edge) and asynchronous active-low reset
//   mode                  system mode; block runs only when mode == MODE_ENC
//   Public_key, P_K_ready key from key generation and its valid flag
//   ptxt/_valid/_ready    plaintext input handshake
//   ctxt/_valid/_ready    ciphertext output handshake
//   err_key, err_ptxt     one-cycle pulses for out-of-range key / plaintext
//   enc_count             delivered ciphertext counter (only with MSG_ENC_COUNT_EN)
//
// Build option MSG_ENC_COUNT_EN: adds the enc_count port and its 16-bit wrapping counter.
module message_encryptor #(
  parameter logic [7:0] P_PAR    = crypto_pkg::P_PAR,
  parameter logic [1:0] MODE_ENC = crypto_pkg::MODE_ENC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  mode,
  input  logic [7:0]  Public_key,
  input  logic        P_K_ready,
  input  logic [7:0]  ptxt,
  input  logic        ptxt_valid,
  output logic        ptxt_ready,
  output logic [7:0]  ctxt,
  output logic        ctxt_valid,
  input  logic        ctxt_ready,
  output logic        err_key,
  output logic        err_ptxt
`ifdef MSG_ENC_COUNT_EN
  ,
  output logic [15:0] enc_count
`endif
);

  import crypto_pkg::*;

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  enc_state_t r_state;
  logic [7:0] r_key;
  logic [7:0] r_ptxt;
  logic [8:0] r_sum;
  logic [7:0] r_ctxt;
  logic       r_ctxt_valid;
  logic       r_ptxt_ready;
  logic       r_err_key;
  logic       r_err_ptxt;

  // Next-state values
  enc_state_t w_state_nxt;
  logic [7:0] w_key_nxt;
  logic [7:0] w_ptxt_nxt;
  logic [8:0] w_sum_nxt;
  logic [7:0] w_ctxt_nxt;
  logic       w_ctxt_valid_nxt;
  logic       w_ptxt_ready_nxt;
  logic       w_err_key_nxt;
  logic       w_err_ptxt_nxt;

  // Decoded conditions
  logic       w_enabled;
  logic       w_abort;
  logic       w_ptxt_hs;
  logic [7:0] w_red;

  assign w_enabled = (mode == MODE_ENC);

  // Leaving encryption mode or losing the key kills whatever is in flight.
  // This check wins over any handshake seen in the same cycle.
  assign w_abort   = (r_state != S_IDLE) && (!w_enabled || !P_K_ready);

  // r_ptxt_ready is only ever high while in S_WAIT
  assign w_ptxt_hs = ptxt_valid && r_ptxt_ready;

  mod_p_reduce #(
    .P (P_PAR)
  ) u_reduce (
    .i_sum (r_sum),
    .o_res (w_red)
  );

  // ---------------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt      = r_state;
    w_key_nxt        = r_key;
    w_ptxt_nxt       = r_ptxt;
    w_sum_nxt        = r_sum;
    w_ctxt_nxt       = r_ctxt;
    w_ctxt_valid_nxt = r_ctxt_valid;
    w_err_key_nxt    = 1'b0;
    w_err_ptxt_nxt   = 1'b0;

    if (w_abort) begin
      w_state_nxt      = S_IDLE;
      w_ctxt_valid_nxt = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_enabled && P_K_ready) begin
            w_key_nxt = Public_key;
            // An out-of-range key is flagged and the block keeps waiting
            // for the key stage to offer a usable one.
            if (Public_key >= P_PAR) begin
              w_err_key_nxt = 1'b1;
            end else begin
              w_state_nxt = S_WAIT;
            end
          end
        end

        S_WAIT: begin
          if (w_ptxt_hs) begin
            // Out-of-range plaintext is consumed and dropped so the
            // producer is never stalled by a bad byte.
            if (ptxt >= P_PAR) begin
              w_err_ptxt_nxt = 1'b1;
            end else begin
              w_ptxt_nxt  = ptxt;
              w_state_nxt = S_ADD;
            end
          end
        end

        S_ADD: begin
          w_sum_nxt   = {1'b0, r_ptxt} + {1'b0, r_key};
          w_state_nxt = S_RED;
        end

        S_RED: begin
          w_ctxt_nxt       = w_red;
          w_ctxt_valid_nxt = 1'b1;
          w_state_nxt      = S_OUT;
        end

        S_OUT: begin
          if (ctxt_ready) begin
            w_ctxt_valid_nxt = 1'b0;
            w_state_nxt      = S_WAIT;
          end
        end

        default: begin
          w_state_nxt      = S_IDLE;
          w_ctxt_valid_nxt = 1'b0;
        end
      endcase
    end

    // Registered ready: high exactly in the cycles spent in S_WAIT
    w_ptxt_ready_nxt = (w_state_nxt == S_WAIT);
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_key        <= 8'd0;
      r_ptxt       <= 8'd0;
      r_sum        <= 9'd0;
      r_ctxt       <= 8'd0;
      r_ctxt_valid <= 1'b0;
      r_ptxt_ready <= 1'b0;
      r_err_key    <= 1'b0;
      r_err_ptxt   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_key        <= w_key_nxt;
      r_ptxt       <= w_ptxt_nxt;
      r_sum        <= w_sum_nxt;
      r_ctxt       <= w_ctxt_nxt;
      r_ctxt_valid <= w_ctxt_valid_nxt;
      r_ptxt_ready <= w_ptxt_ready_nxt;
      r_err_key    <= w_err_key_nxt;
      r_err_ptxt   <= w_err_ptxt_nxt;
    end
  end

  assign ptxt_ready = r_ptxt_ready;
  assign ctxt       = r_ctxt;
  assign ctxt_valid = r_ctxt_valid;
  assign err_key    = r_err_key;
  assign err_ptxt   = r_err_ptxt;

`ifdef MSG_ENC_COUNT_EN
  // ---------------------------------------------------------------------------
  // Delivered-ciphertext counter; survives aborts, cleared only by reset
  // ---------------------------------------------------------------------------
  logic [15:0] r_enc_count;
  logic        w_ctxt_hs;

  // An abort in the same cycle discards the byte, so it is not counted
  assign w_ctxt_hs = (r_state == S_OUT) && r_ctxt_valid && ctxt_ready && !w_abort;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_enc_count <= 16'd0;
    end else if (w_ctxt_hs) begin
      r_enc_count <= r_enc_count + 16'd1;
    end
  end

  assign enc_count = r_enc_count;
`endif

endmodule : message_encryptor

// File: tb/tb_message_encryptor.sv
// Self-checking bench for message_encryptor: directed cases plus randomized traffic.
// Latency: n/a.
// Backpressure: randomized ctxt_ready during the random phase.
module tb_message_encryptor;

  localparam int P = 227;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  mode;
  logic [7:0]  Public_key;
  logic        P_K_ready;
  logic [7:0]  ptxt;
  logic        ptxt_valid;
  logic        ptxt_ready;
  logic [7:0]  ctxt;
  logic        ctxt_valid;
  logic        ctxt_ready;
  logic        err_key;
  logic        err_ptxt;
`ifdef MSG_ENC_COUNT_EN
  logic [15:0] enc_count;
`endif

  int          n_cmp = 0;
  int          n_err = 0;
  logic [15:0] mon_cnt;
  int          q[$];

  message_encryptor dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mode       (mode),
    .Public_key (Public_key),
    .P_K_ready  (P_K_ready),
    .ptxt       (ptxt),
    .ptxt_valid (ptxt_valid),
    .ptxt_ready (ptxt_ready),
    .ctxt       (ctxt),
    .ctxt_valid (ctxt_valid),
    .ctxt_ready (ctxt_ready),
    .err_key    (err_key),
    .err_ptxt   (err_ptxt)
`ifdef MSG_ENC_COUNT_EN
    ,
    .enc_count  (enc_count)
`endif
  );

  always #5 clk = ~clk;

  // Expected delivered-byte count: every output handshake while the block
  // stays enabled with a live key; cleared by reset only.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      mon_cnt <= 16'd0;
    else if (ctxt_valid && ctxt_ready && mode == 2'b10 && P_K_ready)
      mon_cnt <= mon_cnt + 16'd1;
  end

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int ref_enc(input int k, input int m);
    return (k + m) % P;
  endfunction

  task automatic load_key(input int k);
    mode       = 2'b10;
    Public_key = 8'(k);
    P_K_ready  = 1'b1;
    step();
  endtask

  task automatic revoke();
    P_K_ready = 1'b0;
    step();
  endtask

  // Assumes S_WAIT and ctxt_ready = 1; checks exact latency and result.
  task automatic send_and_check(input string tag, input int m, input int exp);
    ptxt       = 8'(m);
    ptxt_valid = 1'b1;
    step();                                   // edge N: accepted
    ptxt_valid = 1'b0;
    check({tag, "_busy_n"}, int'(ptxt_ready), 0);
    check({tag, "_vld_n"},  int'(ctxt_valid), 0);
    step();                                   // edge N+1
    check({tag, "_vld_n1"}, int'(ctxt_valid), 0);
    step();                                   // edge N+2
    check({tag, "_vld_n2"}, int'(ctxt_valid), 1);
    check({tag, "_ctxt"},   int'(ctxt), exp);
    check({tag, "_busy_n2"}, int'(ptxt_ready), 0);
    step();                                   // edge N+3
    check({tag, "_vld_n3"}, int'(ctxt_valid), 0);
    check({tag, "_rdy_n3"}, int'(ptxt_ready), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int key;
    int cnt_before;
    bit exp_err;

    rst_n      = 1'b0;
    mode       = 2'b00;
    Public_key = 8'd0;
    P_K_ready  = 1'b0;
    ptxt       = 8'd0;
    ptxt_valid = 1'b0;
    ctxt_ready = 1'b1;

    // Reset state
    repeat (2) step();
    check("rst_ptxt_ready", int'(ptxt_ready), 0);
    check("rst_ctxt",       int'(ctxt), 0);
    check("rst_ctxt_valid", int'(ctxt_valid), 0);
    check("rst_err_key",    int'(err_key), 0);
    check("rst_err_ptxt",   int'(err_ptxt), 0);
`ifdef MSG_ENC_COUNT_EN
    check("rst_enc_count",  int'(enc_count), 0);
`endif
    rst_n = 1'b1;
    step();

    // Key offered in the wrong mode is ignored
    mode = 2'b01; Public_key = 8'd10; P_K_ready = 1'b1;
    step();
    check("wrong_mode_rdy", int'(ptxt_ready), 0);

    // Basic encryption
    load_key(10);
    check("key10_rdy", int'(ptxt_ready), 1);
    check("key10_err", int'(err_key), 0);
    send_and_check("k10_m100", 100, 110);

    // Wrap case
    revoke();
    check("revoke_rdy", int'(ptxt_ready), 0);
    load_key(200);
    send_and_check("k200_m50", 50, 23);

    // Maximum operands and boundary sums
    revoke();
    load_key(226);
    send_and_check("k226_m226", 226, 225);
    send_and_check("k226_m0", 0, 226);
    send_and_check("k226_m1", 1, 0);

    // Out-of-range plaintext
    ptxt = 8'd230; ptxt_valid = 1'b1;
    step();
    ptxt_valid = 1'b0;
    check("badp_err",     int'(err_ptxt), 1);
    check("badp_rdy",     int'(ptxt_ready), 1);
    check("badp_vld",     int'(ctxt_valid), 0);
    step();
    check("badp_err_off", int'(err_ptxt), 0);
    check("badp_rdy2",    int'(ptxt_ready), 1);
    check("badp_vld2",    int'(ctxt_valid), 0);
    step();
    check("badp_vld3",    int'(ctxt_valid), 0);

    // Out-of-range keys (240 and the exact boundary 227)
    revoke();
    load_key(240);
    check("badk240_err", int'(err_key), 1);
    check("badk240_rdy", int'(ptxt_ready), 0);
    revoke();
    check("badk240_err_off", int'(err_key), 0);
    check("badk240_idle",    int'(ptxt_ready), 0);
    load_key(227);
    check("badk227_err", int'(err_key), 1);
    check("badk227_rdy", int'(ptxt_ready), 0);
    revoke();

    // Backpressure
    load_key(5);
    ctxt_ready = 1'b0;
    ptxt = 8'd7; ptxt_valid = 1'b1;
    step();
    ptxt_valid = 1'b0;
    step(); step();
    check("bp_vld", int'(ctxt_valid), 1);
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_hold_vld",  int'(ctxt_valid), 1);
      check("bp_hold_ctxt", int'(ctxt), 12);
      check("bp_hold_rdy",  int'(ptxt_ready), 0);
    end
    cnt_before = int'(mon_cnt);
    ctxt_ready = 1'b1;
    step();
    check("bp_rel_vld", int'(ctxt_valid), 0);
    check("bp_rel_rdy", int'(ptxt_ready), 1);
`ifdef MSG_ENC_COUNT_EN
    check("bp_rel_cnt", int'(enc_count), cnt_before + 1);
`endif

    // Mode change while in S_ADD
    ptxt = 8'd20; ptxt_valid = 1'b1;
    step();
    ptxt_valid = 1'b0;
    mode = 2'b01;
    step();
    check("abort_vld", int'(ctxt_valid), 0);
    check("abort_rdy", int'(ptxt_ready), 0);
    step(); step();
    check("abort_vld_late", int'(ctxt_valid), 0);
    check("abort_rdy_late", int'(ptxt_ready), 0);
    mode = 2'b10;
    step();
    check("relatch_rdy", int'(ptxt_ready), 1);

    // Key revoked in S_OUT with a simultaneous output handshake
    ctxt_ready = 1'b0;
    ptxt = 8'd3; ptxt_valid = 1'b1;
    step();
    ptxt_valid = 1'b0;
    step(); step();
    check("rev_out_vld", int'(ctxt_valid), 1);
    cnt_before = int'(mon_cnt);
    P_K_ready  = 1'b0;
    ctxt_ready = 1'b1;
    step();
    check("rev_vld", int'(ctxt_valid), 0);
    check("rev_rdy", int'(ptxt_ready), 0);
`ifdef MSG_ENC_COUNT_EN
    check("rev_cnt", int'(enc_count), cnt_before);
`endif

    // Asynchronous reset while holding a ciphertext
    load_key(5);
    ctxt_ready = 1'b0;
    ptxt = 8'd9; ptxt_valid = 1'b1;
    step();
    ptxt_valid = 1'b0;
    step(); step();
    check("ares_pre_vld", int'(ctxt_valid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("ares_vld",  int'(ctxt_valid), 0);
    check("ares_ctxt", int'(ctxt), 0);
`ifdef MSG_ENC_COUNT_EN
    check("ares_cnt",  int'(enc_count), 0);
`endif
    step();
    rst_n = 1'b1;
    step();

    // Randomized traffic against the queue-based model
    for (int ep = 0; ep < 4; ep++) begin
      ptxt_valid = 1'b0;
      mode = 2'b01;
      step();
      q.delete();
      key = int'($urandom_range(0, P - 1));
      load_key(key);
      check("rnd_key_rdy", int'(ptxt_ready), 1);
      for (int cyc = 0; cyc < 150; cyc++) begin
        ptxt_valid = 1'($urandom_range(0, 1));
        ptxt = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(P, 255))
                                           : 8'($urandom_range(0, P - 1));
        ctxt_ready = ($urandom_range(0, 3) != 0);
        check("rnd_no_overlap", int'(ptxt_ready && q.size() > 0), 0);
        if (ctxt_valid && ctxt_ready) begin
          if (q.size() == 0) check("rnd_spurious_ctxt", 1, 0);
          else               check("rnd_ctxt", int'(ctxt), q.pop_front());
        end
        exp_err = 1'b0;
        if (ptxt_valid && ptxt_ready) begin
          if (int'(ptxt) < P) q.push_back(ref_enc(key, int'(ptxt)));
          else                exp_err = 1'b1;
        end
        step();
        check("rnd_err_ptxt", int'(err_ptxt), int'(exp_err));
      end
      ptxt_valid = 1'b0;
      ctxt_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
        if (ctxt_valid) begin
          if (q.size() == 0) check("drain_spurious_ctxt", 1, 0);
          else               check("drain_ctxt", int'(ctxt), q.pop_front());
        end
        step();
      end
      check("drain_empty", q.size(), 0);
    end
`ifdef MSG_ENC_COUNT_EN
    check("final_enc_count", int'(enc_count), int'(mon_cnt));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_message_encryptor
